// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold-time preemption and a registered one-hot grant.
// Define BUS_ARBITER_TURNAROUND_EN to insert one all-low TURN cycle at every handover.
module bus_arbiter #(
   parameter int unsigned N_REQ    = 6,
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_REQ-1:0] REQ,
   output logic [N_REQ-1:0] GNT,
   output logic [N_REQ-1:0] N_OE,
   output logic [2:0]       OWNER,
   output logic             BUS_IDLE
);

   localparam int unsigned   HW        = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam int unsigned   IW        = (N_REQ < 2) ? 1 : $clog2(N_REQ);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX < 1) ? 0 : HOLD_MAX - 1);
   localparam logic [IW-1:0] LAST_RST  = IW'(N_REQ - 1);

`ifdef BUS_ARBITER_TURNAROUND_EN
   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
`else
   typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]    last_q, last_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [N_REQ-1:0] cand;
   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic             owner_req;
   logic             others;
   logic             preempt;
   logic             arb;

   // Candidates exclude the current owner, so a preemption never re-selects it.
   always_comb begin
      logic [IW-1:0] idx;
      idx        = '0;
      cand       = REQ & ~gnt_q;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = IW'((32'(last_q) + 32'd1 + k) % N_REQ);
         if (!pick_valid && cand[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   assign owner_req = |(REQ & gnt_q);
   assign others    = |cand;
   // hold_q is zero in the first granted cycle, so HOLD_LAST marks the HOLD_MAX-th one.
   assign preempt   = others && (hold_q >= HOLD_LAST);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      hold_d  = hold_q;
      arb     = 1'b0;
      case (state_q)
         GRANT: begin
            if (owner_req && !preempt) begin
               if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
            end else begin
               gnt_d   = '0;
               state_d = IDLE;
`ifdef BUS_ARBITER_TURNAROUND_EN
               if (others) state_d = TURN;
`else
               arb = 1'b1;
`endif
            end
         end
         default: arb = 1'b1;
      endcase
      if (arb) begin
         gnt_d = '0;
         if (pick_valid) begin
            gnt_d[pick_idx] = 1'b1;
            last_d          = pick_idx;
            hold_d          = '0;
            state_d         = GRANT;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign GNT      = gnt_q;
   assign N_OE     = ~gnt_q;
   assign BUS_IDLE = ~|gnt_q;

   always_comb begin
      OWNER = 3'b111;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (gnt_q[k]) OWNER = 3'(k);
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle model comparison plus directed literal checks.
module tb_bus_arbiter;

   localparam int N  = 6;
   localparam int HM = 15;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] REQ = '0;
   logic [5:0] GNT;
   logic [5:0] N_OE;
   logic [2:0] OWNER;
   logic       BUS_IDLE;

   int n_cmp = 0;
   int n_bad = 0;

   bus_arbiter #(
      .N_REQ   (N),
      .HOLD_MAX(HM)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .REQ     (REQ),
      .GNT     (GNT),
      .N_OE    (N_OE),
      .OWNER   (OWNER),
      .BUS_IDLE(BUS_IDLE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: owner index (-1 none), last granted index, granted cycles so far (1 in first).
   int         m_own, m_last, m_held;
   int         n_own, n_last, n_held;
   logic [5:0] exp_gnt;
   logic [2:0] exp_owner;

   always_comb begin
      bit others;
      bit found;
      int w;
      n_own  = m_own;
      n_last = m_last;
      n_held = m_held;
      others = 1'b0;
      found  = 1'b0;
      w      = 0;
      if (m_own >= 0) begin
         for (int i = 0; i < N; i++) if (i != m_own && REQ[i]) others = 1'b1;
         if (REQ[m_own] && !(m_held >= HM && others)) n_held = m_held + 1;
         else n_own = -1;
      end
`ifdef BUS_ARBITER_TURNAROUND_EN
      if (m_own < 0) begin
`else
      if (n_own < 0) begin
`endif
         for (int k = 1; k <= N; k++) begin
            w = (m_last + k) % N;
            if (!found && REQ[w] && w != m_own) begin
               found  = 1'b1;
               n_own  = w;
               n_last = w;
               n_held = 1;
            end
         end
      end
   end

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_own  <= -1;
         m_last <= N - 1;
         m_held <= 0;
      end else begin
         m_own  <= n_own;
         m_last <= n_last;
         m_held <= n_held;
      end
   end

   always_comb begin
      exp_gnt   = (m_own >= 0) ? 6'(1 << m_own) : 6'd0;
      exp_owner = (m_own >= 0) ? 3'(m_own) : 3'd7;
   end

   initial begin
      logic [5:0] inv;
      forever begin
         @(negedge CLK);
         inv = ~GNT;
         check("model_gnt", GNT, exp_gnt);
         check("model_owner", OWNER, exp_owner);
         check("model_idle", BUS_IDLE, exp_gnt == 6'd0);
         check("onehot", $countones(GNT) <= 1, 1);
         check("n_oe_inv", N_OE, inv);
      end
   end

   logic [5:0] req_tab [7] = '{6'b101010, 6'b101010, 6'b101000, 6'b101000,
                               6'b100000, 6'b100000, 6'b000000};
`ifdef BUS_ARBITER_TURNAROUND_EN
   logic [5:0] exp_tab [7] = '{6'b000010, 6'b000010, 6'b000000, 6'b001000,
                               6'b000000, 6'b100000, 6'b000000};
`else
   logic [5:0] exp_tab [7] = '{6'b000010, 6'b000010, 6'b001000, 6'b001000,
                               6'b100000, 6'b100000, 6'b000000};
`endif

   // Leaves the bench at a negedge with RST low; the next posedge is edge 1.
   task automatic do_reset();
      @(negedge CLK);
      #2 RST = 1'b1;
      REQ = '0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      int cyc;
      int len;
      REQ = 6'b111111;
      repeat (3) begin
         @(negedge CLK);
         check("rst_gnt", GNT, 0);
         check("rst_noe", N_OE, 6'b111111);
         check("rst_owner", OWNER, 7);
         check("rst_idle", BUS_IDLE, 1);
      end

      // Single requester: grant after edge 1, release after edge 4.
      RST = 1'b0;
      REQ = 6'b000001;
      @(negedge CLK);
      check("single_gnt", GNT, 6'b000001);
      check("single_owner", OWNER, 0);
      @(negedge CLK);
      @(negedge CLK);
      check("single_hold", GNT, 6'b000001);
      REQ = 6'b000000;
      @(negedge CLK);
      check("single_release", GNT, 0);
      check("single_idle", BUS_IDLE, 1);

      // Round-robin 1 -> 3 -> 5.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         REQ = req_tab[i];
         @(negedge CLK);
         check("rr_seq", GNT, exp_tab[i]);
      end

      // Preemption after HM granted cycles of requester 0.
      do_reset();
      REQ = 6'b000001;
      @(negedge CLK);
      @(negedge CLK);
      REQ = 6'b001001;
      repeat (13) @(negedge CLK);
      check("hold_last", GNT, 6'b000001);
      @(negedge CLK);
`ifdef BUS_ARBITER_TURNAROUND_EN
      check("preempt_turn", GNT, 0);
      @(negedge CLK);
`endif
      check("preempt_gnt", GNT, 6'b001000);
      check("preempt_owner", OWNER, 3);

      // Asynchronous reset mid-cycle while requester 3 owns the bus.
      #2 RST = 1'b1;
      #1;
      check("async_gnt", GNT, 0);
      check("async_noe", N_OE, 6'b111111);
      check("async_owner", OWNER, 7);
      check("async_idle", BUS_IDLE, 1);
      @(negedge CLK);
      RST = 1'b0;
      REQ = '0;

      // Sole requester keeps the grant past saturation.
      do_reset();
      REQ = 6'b000001;
      repeat (100) @(negedge CLK);
      check("sole_keep", GNT, 6'b000001);

      // Random request patterns held for random lengths.
      cyc = 0;
      while (cyc < 10000) begin
         REQ = 6'($urandom_range(0, 63));
         len = $urandom_range(1, 20);
         repeat (len) @(negedge CLK);
         cyc += len;
      end
      REQ = '0;
      @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 6, number of bus requesters (bit 0 reg, 1 tmp0, 2 tmp1, 3 mlu, 4 shifter, 5 timer).
REQ-002 SHALL have parameter HOLD_MAX, default 15, granted cycles after which an owner is preempted if others wait.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REQ  input  N_REQ  per-requester bus request, level-sensitive, held while bus is wanted.
REQ-006 SHALL have port GNT  output  N_REQ  registered one-hot grant.
REQ-007 SHALL have port N_OE  output  N_REQ  active-low buffer output enables, bitwise inverse of GNT.
REQ-008 SHALL have port OWNER  output  3  encoded index of granted requester; 3'b111 when none.
REQ-009 SHALL have port BUS_IDLE  output  1  high when no GNT bit is set.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT and TURN; TURN SHALL exist only when BUS_TURNAROUND_EN is defined.
REQ-011 SHALL never assert more than one GNT bit in any cycle; N_OE SHALL equal ~GNT in every cycle, including reset.
REQ-012 SHALL, in IDLE, sample REQ at a rising edge and assert GNT for the selected requester at that same edge (one-cycle latency from REQ rise to GNT).
REQ-013 SHALL select round-robin: search starts at index (last_owner+1) mod N_REQ, first set REQ bit wins; last_owner updates on every new grant.
REQ-014 SHALL keep GNT stable in GRANT while the owner's REQ stays high and no preemption occurs.
REQ-015 SHALL, on owner REQ low sampled at an edge, clear GNT at that edge; without BUS_TURNAROUND_EN, SHALL grant the next waiting requester at the same edge (back-to-back).
REQ-016 SHALL count owner-granted cycles in a hold counter (width ceil(log2(HOLD_MAX+1))), cleared on each new grant, saturating at HOLD_MAX.
REQ-017 SHALL, when hold counter equals HOLD_MAX and any other REQ bit is high, revoke the grant at the next edge and select the next owner excluding the current owner.
REQ-018 SHALL, when hold counter equals HOLD_MAX and no other request is pending, keep the owner granted indefinitely.
REQ-019 SHALL return to IDLE with BUS_IDLE high when no REQ bit is set at a release edge.
REQ-020 SHALL ignore REQ bits at indices >= N_REQ and SHALL drive OWNER from the registered grant, never from REQ combinationally.
REQ-021 SHALL treat an owner dropping and re-raising REQ as a new request arbitrated round-robin (no priority to previous owner).

Reset
REQ-022 SHALL, while RST is high, immediately force GNT=0, N_OE=all ones, OWNER=3'b111, BUS_IDLE=1, state IDLE, hold counter 0, last_owner=N_REQ-1.
REQ-023 SHALL, on RST asserted mid-grant, drop GNT asynchronously in the same cycle, without waiting for a clock edge.
REQ-024 SHALL perform first arbitration at the first rising edge after RST deasserts; requester 0 wins any tie.

Configuration
REQ-025 SHALL honour macro BUS_ARBITER_TURNAROUND_EN (referred to above as BUS_TURNAROUND_EN): when defined, every grant release or preemption SHALL pass through TURN for exactly one cycle with all GNT low before the next grant; when undefined, TURN SHALL be absent and handover SHALL be back-to-back per REQ-015.

Verification
REQ-026 SHALL cover: RST=1 with REQ=6'b111111 -> GNT=0, N_OE=6'b111111, OWNER=7, BUS_IDLE=1 throughout.
REQ-027 SHALL cover: after reset, REQ=6'b000001 at cycle 0 -> GNT=6'b000001, OWNER=0 after edge 1; REQ low at cycle 3 -> GNT=0, BUS_IDLE=1 after edge 4.
REQ-028 SHALL cover: after reset, REQ=6'b101010 simultaneously, each owner releases after 2 cycles -> grant order 1, 3, 5, with one all-low cycle between grants only when macro defined.
REQ-029 SHALL cover: requester 0 holds REQ continuously, REQ[3] rises at cycle 2 -> GNT moves to 3 after 15 granted cycles of requester 0; with REQ[3] low, requester 0 keeps grant for 100 cycles.
REQ-030 SHALL cover: RST pulsed high mid-cycle while GNT=6'b001000 -> GNT=0 and N_OE=6'b111111 before the next rising edge.
REQ-031 SHALL cover: random REQ for 10000 cycles -> assertion that popcount(GNT) <= 1 and N_OE == ~GNT every cycle.
